sd_buf_streamer: RTL and testbench

SD_BUF_STREAMER -- requirements
Module: sd_buf_streamer

---
 rtl/sd_buf_streamer_if.sv | 36 +++
 rtl/sd_buf_streamer.sv | 148 ++++++++++++++
 tb/tb_sd_buf_streamer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_buf_streamer_if.sv
// Bus bundle for sd_buf_streamer: command channel, fill/drain byte streams, RAM port and status.
// slave is the streamer's view, master is the host/RAM side.
interface sd_buf_streamer_if #(
  parameter int unsigned BUF_BITS   = 1,
  parameter int unsigned ADDR_WIDTH = 9 + BUF_BITS
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_dir;
  logic [BUF_BITS-1:0]   cmd_buf;
  logic                  s_valid;
  logic                  s_ready;
  logic [7:0]            s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [7:0]            m_data;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [7:0]            ram_data;
  logic                  ram_wren;
  logic [7:0]            ram_q;
  logic                  busy;
  logic                  done;
  logic [15:0]           csum;

  modport slave (
    input  cmd_valid, cmd_dir, cmd_buf, s_valid, s_data, m_ready, ram_q,
    output cmd_ready, s_ready, m_valid, m_data, ram_address, ram_data, ram_wren, busy, done,
           csum
  );

  modport master (
    output cmd_valid, cmd_dir, cmd_buf, s_valid, s_data, m_ready, ram_q,
    input  cmd_ready, s_ready, m_valid, m_data, ram_address, ram_data, ram_wren, busy, done,
           csum
  );
endinterface

// File: rtl/sd_buf_streamer.sv
// Moves one 512-byte sector between a byte stream and a sector buffer in RAM (fill or drain).
// Define SD_BUF_STREAMER_CSUM_EN to enable the running 16-bit byte checksum on csum.
module sd_buf_streamer #(
  parameter int unsigned BUF_BITS   = 1,
  parameter int unsigned ADDR_WIDTH = 9 + BUF_BITS
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  sd_buf_streamer_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StFill, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [BUF_BITS-1:0]   sel_q, sel_d;
  logic [8:0]            ptr_q, ptr_d;
  logic                  rd_done_q, rd_done_d;
  logic                  inflight_q;
  logic [1:0]            cnt_q, cnt_d;
  logic [7:0]            f0_q, f0_d, f1_q, f1_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            wdata_q;

  logic                  accept, wr, rd, pop, push;
  logic [1:0]            occ;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [7:0]            m_data;

  assign cur_addr = ADDR_WIDTH'({sel_q, ptr_q});
  // Occupancy counts the byte still in the RAM read pipe so the 2-entry FIFO never overflows.
  assign occ      = cnt_q + {1'b0, inflight_q};

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    rd_done_d = rd_done_q;
    accept    = 1'b0;
    wr        = 1'b0;
    rd        = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          accept    = 1'b1;
          sel_d     = bus.cmd_buf;
          ptr_d     = '0;
          rd_done_d = 1'b0;
          state_d   = bus.cmd_dir ? StDrain : StFill;
        end
      end
      StFill: begin
        if (bus.s_valid) begin
          wr    = 1'b1;
          ptr_d = ptr_q + 9'd1;
          if (ptr_q == 9'd511) state_d = StDone;
        end
      end
      StDrain: begin
        rd = !rd_done_q && (occ < 2'd2);
        if (rd) begin
          ptr_d = ptr_q + 9'd1;
          if (ptr_q == 9'd511) rd_done_d = 1'b1;
        end
        pop = ((cnt_q != 2'd0) || inflight_q) && bus.m_ready;
        if (pop && rd_done_q && (occ == 2'd1)) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Arriving RAM data bypasses an empty FIFO, so it is only stored if not consumed at once.
  assign push = inflight_q && !((cnt_q == 2'd0) && pop);

  always_comb begin
    f0_d  = f0_q;
    f1_d  = f1_q;
    cnt_d = cnt_q;
    if (pop && (cnt_q != 2'd0)) begin
      f0_d  = f1_q;
      cnt_d = cnt_q - 2'd1;
    end
    if (push) begin
      if (cnt_d == 2'd0) f0_d = bus.ram_q;
      else               f1_d = bus.ram_q;
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      ptr_q      <= '0;
      rd_done_q  <= 1'b0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      f0_q       <= '0;
      f1_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      rd_done_q  <= rd_done_d;
      inflight_q <= rd;
      cnt_q      <= cnt_d;
      f0_q       <= f0_d;
      f1_q       <= f1_d;
      if (wr || rd) addr_q  <= cur_addr;
      if (wr)       wdata_q <= bus.s_data;
    end
  end

  assign m_data          = (cnt_q != 2'd0) ? f0_q : bus.ram_q;
  assign bus.m_data      = m_data;
  assign bus.m_valid     = (state_q == StDrain) && ((cnt_q != 2'd0) || inflight_q);
  assign bus.s_ready     = (state_q == StFill);
  assign bus.cmd_ready   = (state_q == StIdle);
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StDone);
  assign bus.ram_wren    = wr;
  assign bus.ram_data    = wr ? bus.s_data : wdata_q;
  assign bus.ram_address = (wr || rd) ? cur_addr : addr_q;

`ifdef SD_BUF_STREAMER_CSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= '0;
    end else if (accept) begin
      csum_q <= '0;
    end else if (wr) begin
      csum_q <= csum_q + {8'h00, bus.s_data};
    end else if (pop) begin
      csum_q <= csum_q + {8'h00, m_data};
    end
  end

  assign bus.csum = csum_q;
`else
  assign bus.csum = 16'h0000;
`endif

endmodule

// File: tb/tb_sd_buf_streamer.sv
// Randomized bench for sd_buf_streamer with a RAM model and an address-indexed expected-memory model.
module tb_sd_buf_streamer;
  localparam int unsigned BufBits   = 1;
  localparam int unsigned AddrWidth = 9 + BufBits;
  localparam int unsigned RamWords  = 1 << AddrWidth;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;

  sd_buf_streamer_if #(.BUF_BITS(BufBits), .ADDR_WIDTH(AddrWidth)) bus ();

  sd_buf_streamer #(.BUF_BITS(BufBits), .ADDR_WIDTH(AddrWidth)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0] ram     [RamWords];
  logic [7:0] exp_mem [RamWords];
  logic [7:0] pat     [512];
  logic       ram_init = 1'b0;

  // Synchronous RAM: read data one clock after the address, preloaded with addr & 0xFF.
  always @(posedge clk_sys) begin
    if (!ram_init) begin
      for (int i = 0; i < RamWords; i++) ram[i] = 8'(i);
      ram_init = 1'b1;
    end
    bus.ram_q <= ram[bus.ram_address];
    if (bus.ram_wren) ram[bus.ram_address] = bus.ram_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] csum_exp(input logic [15:0] sum);
`ifdef SD_BUF_STREAMER_CSUM_EN
    return sum;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic next_cycle();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_cmd(input logic dir, input logic [BufBits-1:0] b);
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = dir;
    bus.cmd_buf   = b;
    @(negedge clk_sys);
    check("cmd_ready", 32'(bus.cmd_ready), 32'd1);
    next_cycle();
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = $urandom_range(0, 1);
  endtask

  task automatic idle_after_done(input logic [15:0] sum);
    next_cycle();
    @(negedge clk_sys);
    check("idle_done", 32'(bus.done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("idle_wren", 32'(bus.ram_wren), 32'd0);
    check("idle_csum", 32'(bus.csum), 32'(csum_exp(sum)));
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    next_cycle();
  endtask

  // mode: 0 ramp, 1 random bytes, 2 all 0xFF
  task automatic run_fill(input logic [BufBits-1:0] b, input int mode, input bit rand_valid);
    int          k   = 0;
    int          cyc = 1;
    logic [15:0] sum = '0;
    for (int i = 0; i < 512; i++)
      pat[i] = (mode == 0) ? 8'(i) : (mode == 1) ? 8'($urandom) : 8'hFF;
    send_cmd(1'b0, b);
    while (k < 512 && cyc < 4000) begin
      bus.s_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.s_data  = pat[k];
      @(negedge clk_sys);
      check("fill_s_ready", 32'(bus.s_ready), 32'd1);
      check("fill_wren", 32'(bus.ram_wren), 32'(bus.s_valid));
      if (bus.s_valid) begin
        check("fill_addr", 32'(bus.ram_address), 32'({b, k[8:0]}));
        check("fill_data", 32'(bus.ram_data), 32'(pat[k]));
        exp_mem[{b, k[8:0]}] = pat[k];
        sum = sum + 16'(pat[k]);
        k++;
      end
      next_cycle();
      cyc++;
    end
    check("fill_count", 32'(k), 32'd512);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'($urandom);
    @(negedge clk_sys);
    check("fill_done", 32'(bus.done), 32'd1);
    check("fill_done_s_ready", 32'(bus.s_ready), 32'd0);
    check("fill_done_wren", 32'(bus.ram_wren), 32'd0);
    check("fill_done_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("fill_csum", 32'(bus.csum), 32'(csum_exp(sum)));
    if (!rand_valid) check("fill_done_cycle", 32'(cyc), 32'd513);
    idle_after_done(sum);
  endtask

  // mode: 0 m_ready high, 1 m_ready 1,0,0 repeating, 2 random m_ready
  task automatic run_drain(input logic [BufBits-1:0] b, input int mode);
    int          k     = 0;
    int          cyc   = 1;
    int          first = -1;
    int          last  = -1;
    logic [15:0] sum   = '0;
    logic        r;
    send_cmd(1'b1, b);
    while (k < 512 && cyc < 4000) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc - 1) % 3 == 0) : 1'($urandom_range(0, 1));
      bus.m_ready = r;
      bus.s_valid = 1'($urandom_range(0, 1));
      @(negedge clk_sys);
      check("drain_wren", 32'(bus.ram_wren), 32'd0);
      check("drain_s_ready", 32'(bus.s_ready), 32'd0);
      if (mode == 0 && cyc >= 2) check("drain_no_gap", 32'(bus.m_valid), 32'd1);
      if (bus.m_valid) begin
        if (first < 0) first = cyc;
        check("drain_data", 32'(bus.m_data), 32'(exp_mem[{b, k[8:0]}]));
        if (r) begin
          sum  = sum + 16'(exp_mem[{b, k[8:0]}]);
          last = cyc;
          k++;
        end
      end
      next_cycle();
      cyc++;
    end
    check("drain_count", 32'(k), 32'd512);
    bus.m_ready = 1'b1;
    @(negedge clk_sys);
    check("drain_done", 32'(bus.done), 32'd1);
    check("drain_done_m_valid", 32'(bus.m_valid), 32'd0);
    check("drain_done_cycle", 32'(cyc), 32'(last + 1));
    check("drain_csum", 32'(bus.csum), 32'(csum_exp(sum)));
    if (mode == 0) check("drain_first_valid", 32'(first), 32'd2);
    idle_after_done(sum);
  endtask

  task automatic idle_poke();
    repeat (3) begin
      bus.s_valid = 1'b1;
      bus.m_ready = 1'b1;
      bus.s_data  = 8'($urandom);
      @(negedge clk_sys);
      check("poke_wren", 32'(bus.ram_wren), 32'd0);
      check("poke_s_ready", 32'(bus.s_ready), 32'd0);
      check("poke_m_valid", 32'(bus.m_valid), 32'd0);
      check("poke_busy", 32'(bus.busy), 32'd0);
      next_cycle();
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
  endtask

  task automatic reset_mid_drain();
    int k   = 0;
    int cyc = 0;
    send_cmd(1'b1, 1'b1);
    bus.m_ready = 1'b1;
    while (k < 200 && cyc < 1000) begin
      @(negedge clk_sys);
      if (bus.m_valid) begin
        check("rst_drain_data", 32'(bus.m_data), 32'(exp_mem[{1'b1, k[8:0]}]));
        k++;
      end
      next_cycle();
      cyc++;
    end
    check("rst_drain_count", 32'(k), 32'd200);
    reset_n = 1'b0;
    #1;
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_addr", 32'(bus.ram_address), 32'd0);
    check("rst_csum", 32'(bus.csum), 32'd0);
    repeat (2) begin
      next_cycle();
      check("rst_hold_done", 32'(bus.done), 32'd0);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    next_cycle();
    @(negedge clk_sys);
    check("rst_release_done", 32'(bus.done), 32'd0);
    check("rst_release_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    next_cycle();
    bus.m_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_buf   = '0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.m_ready   = 1'b0;
    for (int i = 0; i < RamWords; i++) exp_mem[i] = 8'(i);
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_s_ready", 32'(bus.s_ready), 32'd0);
    check("reset_m_valid", 32'(bus.m_valid), 32'd0);
    check("reset_wren", 32'(bus.ram_wren), 32'd0);
    check("reset_addr", 32'(bus.ram_address), 32'd0);
    check("reset_ram_data", 32'(bus.ram_data), 32'd0);
    check("reset_csum", 32'(bus.csum), 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    next_cycle();

    run_fill(1'b1, 0, 1'b0);
    run_drain(1'b0, 0);
    run_drain(1'b1, 1);
    run_fill(1'b0, 1, 1'b1);
    run_drain(1'b0, 2);
    idle_poke();
    run_fill(1'b0, 2, 1'b0);
    run_drain(1'b0, 1);
    reset_mid_drain();
    run_fill(1'b1, 1, 1'b1);
    run_drain(1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
